// File: rtl/alarm_pkg.sv
// Shared constants and types for the alarm register bank: address map and scanner states.
// Pure declarations; no latency, no backpressure.
package alarm_pkg;

  localparam int ADDR_CUR_HR   = 0;
  localparam int ADDR_CUR_MIN  = 1;
  localparam int ADDR_ALM_BASE = 2;

  // The enable mask sits directly after the last alarm minute register.
  function automatic int mask_addr(input int num_alarms);
    return ADDR_ALM_BASE + 2 * num_alarms;
  endfunction

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/alarm_reg_bank_if.sv
// Byte-wide write port plus registered read port of the alarm register bank.
// Writes take effect next cycle; read data follows rd_en by one cycle; no backpressure.
interface alarm_reg_bank_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              commit;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_err;

  modport master (
    output wr_en, addr, data, commit, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_err
  );

  modport slave (
    input  wr_en, addr, data, commit, rd_en, rd_addr,
    output rd_data, rd_valid, wr_err
  );

endinterface

// File: rtl/alarm_match_scanner.sv
// Walks the alarm slots one per cycle after a trigger and pulses alarm_hit on an enabled time match.
// Hit is registered one cycle after its compare; a trigger mid-scan restarts at slot 0; no backpressure.
module alarm_match_scanner
  import alarm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trigger,
  input  logic [DATA_W-1:0]            curr_hour,
  input  logic [DATA_W-1:0]            curr_min,
  input  logic [NUM_ALARMS-1:0]        alarm_en,
  input  logic [NUM_ALARMS*DATA_W-1:0] alarm_hr,
  input  logic [NUM_ALARMS*DATA_W-1:0] alarm_min,
  output logic                         alarm_hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic                         scan_busy
);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cmp_hit;

  always_comb begin
    cmp_hit = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cmp_hit = alarm_en[k]
               && (alarm_hr[k*DATA_W +: DATA_W] == curr_hour)
               && (alarm_min[k*DATA_W +: DATA_W] == curr_min);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (trigger) begin
          idx_d = '0;
        end else if (idx_q == IDX_W'(NUM_ALARMS - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // The compare of the current slot is always registered, even on a restart cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      alarm_hit <= 1'b0;
      hit_idx   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      alarm_hit <= (state_q == S_SCAN) && cmp_hit;
      if ((state_q == S_SCAN) && cmp_hit) begin
        hit_idx <= idx_q;
      end
    end
  end

  assign scan_busy = (state_q == S_SCAN);

endmodule

// File: rtl/alarm_reg_bank.sv
// Current time plus NUM_ALARMS alarm slots with checked writes, registered reads and a match scanner.
// Writes visible next cycle, reads one cycle; no backpressure. Optional SHADOW_COMMIT_EN stages writes until commit.
module alarm_reg_bank
  import alarm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_ALARMS = 4,
  parameter int ADDR_W     = 4,
  parameter int MAX_HOUR   = 23,
  parameter int MAX_MIN    = 59,
  localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  alarm_reg_bank_if.slave              bus,
  output logic [DATA_W-1:0]            curr_hour,
  output logic [DATA_W-1:0]            curr_min,
  output logic [NUM_ALARMS-1:0]        alarm_en,
  output logic [NUM_ALARMS*DATA_W-1:0] alarm_hr,
  output logic [NUM_ALARMS*DATA_W-1:0] alarm_min,
  output logic                         alarm_hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic                         scan_busy
);

  localparam int MASK_ADDR = mask_addr(NUM_ALARMS);

  logic                  sel_chr, sel_cmin, sel_mask;
  logic [NUM_ALARMS-1:0] sel_ahr, sel_amin;
  logic                  hr_ok, min_ok, wr_ok, wr_bad;
  logic                  scan_trig;

  always_comb begin
    sel_chr  = (bus.addr == ADDR_W'(ADDR_CUR_HR));
    sel_cmin = (bus.addr == ADDR_W'(ADDR_CUR_MIN));
    sel_mask = (bus.addr == ADDR_W'(MASK_ADDR));
    sel_ahr  = '0;
    sel_amin = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      sel_ahr[k]  = (bus.addr == ADDR_W'(ADDR_ALM_BASE + 2*k));
      sel_amin[k] = (bus.addr == ADDR_W'(ADDR_ALM_BASE + 2*k + 1));
    end
    hr_ok  = (bus.data <= DATA_W'(MAX_HOUR));
    min_ok = (bus.data <= DATA_W'(MAX_MIN));
    wr_ok  = bus.wr_en && ((((sel_chr  || (|sel_ahr))) && hr_ok)
                        || (((sel_cmin || (|sel_amin))) && min_ok)
                        || sel_mask);
    wr_bad = bus.wr_en && !wr_ok;
  end

  // Visible registers drive the outputs, the read port and the scanner.
  logic [DATA_W-1:0]     vis_chr, vis_cmin;
  logic [DATA_W-1:0]     vis_ahr  [NUM_ALARMS];
  logic [DATA_W-1:0]     vis_amin [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] vis_en;

  // Write target (visible or shadow copy) and its value after this cycle's write.
  logic [DATA_W-1:0]     base_chr, base_cmin, nxt_chr, nxt_cmin;
  logic [DATA_W-1:0]     base_ahr  [NUM_ALARMS];
  logic [DATA_W-1:0]     base_amin [NUM_ALARMS];
  logic [DATA_W-1:0]     nxt_ahr   [NUM_ALARMS];
  logic [DATA_W-1:0]     nxt_amin  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] base_en, nxt_en;

  always_comb begin
    nxt_chr  = base_chr;
    nxt_cmin = base_cmin;
    nxt_ahr  = base_ahr;
    nxt_amin = base_amin;
    nxt_en   = base_en;
    if (wr_ok) begin
      if (sel_chr)  nxt_chr  = bus.data;
      if (sel_cmin) nxt_cmin = bus.data;
      if (sel_mask) nxt_en   = bus.data[NUM_ALARMS-1:0];
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (sel_ahr[k])  nxt_ahr[k]  = bus.data;
        if (sel_amin[k]) nxt_amin[k] = bus.data;
      end
    end
  end

`ifdef SHADOW_COMMIT_EN
  logic [DATA_W-1:0]     sh_chr, sh_cmin;
  logic [DATA_W-1:0]     sh_ahr  [NUM_ALARMS];
  logic [DATA_W-1:0]     sh_amin [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] sh_en;

  assign base_chr  = sh_chr;
  assign base_cmin = sh_cmin;
  assign base_ahr  = sh_ahr;
  assign base_amin = sh_amin;
  assign base_en   = sh_en;

  // Commit publishes the shadow including any write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_chr   <= '0;
      sh_cmin  <= '0;
      sh_en    <= '0;
      vis_chr  <= '0;
      vis_cmin <= '0;
      vis_en   <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        sh_ahr[k]   <= '0;
        sh_amin[k]  <= '0;
        vis_ahr[k]  <= '0;
        vis_amin[k] <= '0;
      end
    end else begin
      sh_chr  <= nxt_chr;
      sh_cmin <= nxt_cmin;
      sh_ahr  <= nxt_ahr;
      sh_amin <= nxt_amin;
      sh_en   <= nxt_en;
      if (bus.commit) begin
        vis_chr  <= nxt_chr;
        vis_cmin <= nxt_cmin;
        vis_ahr  <= nxt_ahr;
        vis_amin <= nxt_amin;
        vis_en   <= nxt_en;
      end
    end
  end

  assign scan_trig = bus.commit;
`else
  logic unused_commit;
  assign unused_commit = bus.commit;

  assign base_chr  = vis_chr;
  assign base_cmin = vis_cmin;
  assign base_ahr  = vis_ahr;
  assign base_amin = vis_amin;
  assign base_en   = vis_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_chr  <= '0;
      vis_cmin <= '0;
      vis_en   <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        vis_ahr[k]  <= '0;
        vis_amin[k] <= '0;
      end
    end else begin
      vis_chr  <= nxt_chr;
      vis_cmin <= nxt_cmin;
      vis_ahr  <= nxt_ahr;
      vis_amin <= nxt_amin;
      vis_en   <= nxt_en;
    end
  end

  // Only a change of the current time can create a new match.
  assign scan_trig = wr_ok && (sel_chr || sel_cmin);
`endif

  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (bus.rd_addr == ADDR_W'(ADDR_CUR_HR))  rd_mux = vis_chr;
    if (bus.rd_addr == ADDR_W'(ADDR_CUR_MIN)) rd_mux = vis_cmin;
    if (bus.rd_addr == ADDR_W'(MASK_ADDR))    rd_mux = DATA_W'(vis_en);
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (bus.rd_addr == ADDR_W'(ADDR_ALM_BASE + 2*k))     rd_mux = vis_ahr[k];
      if (bus.rd_addr == ADDR_W'(ADDR_ALM_BASE + 2*k + 1)) rd_mux = vis_amin[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.wr_err   <= wr_bad;
      if (bus.rd_en) begin
        bus.rd_data <= rd_mux;
      end
    end
  end

  assign curr_hour = vis_chr;
  assign curr_min  = vis_cmin;
  assign alarm_en  = vis_en;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_pack
    assign alarm_hr[g*DATA_W +: DATA_W]  = vis_ahr[g];
    assign alarm_min[g*DATA_W +: DATA_W] = vis_amin[g];
  end

  alarm_match_scanner #(
    .DATA_W     (DATA_W),
    .NUM_ALARMS (NUM_ALARMS),
    .IDX_W      (IDX_W)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .trigger   (scan_trig),
    .curr_hour (vis_chr),
    .curr_min  (vis_cmin),
    .alarm_en  (vis_en),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .alarm_hit (alarm_hit),
    .hit_idx   (hit_idx),
    .scan_busy (scan_busy)
  );

endmodule

// File: tb/tb_alarm_reg_bank.sv
// Bench for alarm_reg_bank: directed vector table, corner sequences and random traffic vs an address-indexed model.
module tb_alarm_reg_bank;

  localparam int DW    = 8;
  localparam int NA    = 4;
  localparam int AW    = 4;
  localparam int MH    = 23;
  localparam int MM    = 59;
  localparam int IW    = 2;
  localparam int MASKA = 2 + 2*NA;
  localparam int NREG  = MASKA + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [DW-1:0]    curr_hour, curr_min;
  logic [NA-1:0]    alarm_en;
  logic [NA*DW-1:0] alarm_hr, alarm_min;
  logic             alarm_hit, scan_busy;
  logic [IW-1:0]    hit_idx;

  alarm_reg_bank #(
    .DATA_W(DW), .NUM_ALARMS(NA), .ADDR_W(AW), .MAX_HOUR(MH), .MAX_MIN(MM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .curr_hour (curr_hour),
    .curr_min  (curr_min),
    .alarm_en  (alarm_en),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .alarm_hit (alarm_hit),
    .hit_idx   (hit_idx),
    .scan_busy (scan_busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: registers indexed by address; a scan covers slot (cycle - scan_start).
  int vis [NREG];
  int sh  [NREG];
  int m_rdat;
  int cyc = 0;
  int scan_start = -1000;

  int hit_cnt, busy_cnt;
  int hit_cyc [$];
  int hit_ix  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit wr_legal(input int a, input int d);
    if (a == 0) return d <= MH;
    if (a == 1) return d <= MM;
    if (a >= 2 && a < MASKA) return (a % 2 == 0) ? (d <= MH) : (d <= MM);
    if (a == MASKA) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_log();
    hit_cnt  = 0;
    busy_cnt = 0;
    hit_cyc.delete();
    hit_ix.delete();
  endtask

  task automatic cycle(input bit rst, input bit we, input int a, input int d,
                       input bit cm, input bit re, input int ra);
    int  slot;
    bit  hit_now, ok, trig, exp_rvld, exp_err;
    int  hit_slot;
    reset       = rst;
    bus.wr_en   = we;
    bus.addr    = AW'(a);
    bus.data    = DW'(d);
    bus.commit  = cm;
    bus.rd_en   = re;
    bus.rd_addr = AW'(ra);

    slot     = cyc - scan_start;
    hit_now  = 1'b0;
    hit_slot = 0;
    if (!rst && slot >= 0 && slot < NA) begin
      hit_slot = slot;
      hit_now  = (((vis[MASKA] >> slot) & 1) == 1) && vis[2+2*slot] == vis[0]
                 && vis[3+2*slot] == vis[1];
    end
    exp_rvld = re && !rst;
    if (rst) m_rdat = 0;
    else if (re) m_rdat = (ra < NREG) ? vis[ra] : 0;
    ok      = we && wr_legal(a, d);
    exp_err = we && !ok && !rst;
    trig    = 1'b0;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin vis[i] = 0; sh[i] = 0; end
      scan_start = -1000;
    end else begin
`ifdef SHADOW_COMMIT_EN
      if (ok) sh[a] = (a == MASKA) ? d % (1 << NA) : d;
      if (cm) begin vis = sh; trig = 1'b1; end
`else
      if (ok) vis[a] = (a == MASKA) ? d % (1 << NA) : d;
      trig = ok && a <= 1;
`endif
      if (trig) scan_start = cyc + 1;
    end

    @(posedge clk);
    #1;
    cyc++;

    chk("rd_valid", bus.rd_valid, exp_rvld);
    if (exp_rvld || rst) chk("rd_data", bus.rd_data, m_rdat);
    chk("wr_err", bus.wr_err, exp_err);
    chk("curr_hour", curr_hour, vis[0]);
    chk("curr_min", curr_min, vis[1]);
    chk("alarm_en", alarm_en, vis[MASKA]);
    for (int k = 0; k < NA; k++) begin
      chk("alarm_hr", alarm_hr[k*DW +: DW], vis[2+2*k]);
      chk("alarm_min", alarm_min[k*DW +: DW], vis[3+2*k]);
    end
    chk("alarm_hit", alarm_hit, hit_now);
    if (hit_now) chk("hit_idx", hit_idx, hit_slot);
    if (rst) chk("hit_idx_rst", hit_idx, 0);
    chk("scan_busy", scan_busy, (cyc - scan_start >= 0) && (cyc - scan_start < NA));

    if (alarm_hit) begin
      hit_cnt++;
      hit_cyc.push_back(cyc);
      hit_ix.push_back(int'(hit_idx));
    end
    if (scan_busy) busy_cnt++;
  endtask

  task automatic wr(input int a, input int d);
    cycle(1'b0, 1'b1, a, d, 1'b0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    idle(1);
  endtask

  typedef struct {
    bit we; int a; int d; bit re; int ra;
    int e_err; int e_rvld; int e_rdat;
  } vec_t;

  vec_t tbl [$];

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.addr = '0; bus.data = '0;
    bus.commit = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    for (int i = 0; i < NREG; i++) begin vis[i] = 0; sh[i] = 0; end
    m_rdat = 0;
    clear_log();

    for (int a = 0; a <= 10; a++) tbl.push_back('{1'b0, 0, 0, 1'b1, a, 0, 1, 0});
`ifndef SHADOW_COMMIT_EN
    tbl.push_back('{1'b1, 0, 24, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 0, 0, 1, 0});
    tbl.push_back('{1'b1, 0, 23, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 0, 0, 1, 23});
    tbl.push_back('{1'b1, 11, 5, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{1'b1, 15, 5, 1'b1, 15, 1, 1, 0});
    tbl.push_back('{1'b1, 10, 255, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 10, 0, 1, 15});
    tbl.push_back('{1'b1, 3, 60, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{1'b1, 3, 59, 1'b1, 3, 0, 1, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 3, 0, 1, 59});
    tbl.push_back('{1'b1, 1, 45, 1'b1, 1, 0, 1, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1, 0, 1, 45});
    tbl.push_back('{1'b1, 2, 23, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 4, 24, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{1'b1, 5, 10, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 5, 11, 1'b0, 0, 0, 0, 0});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 5, 0, 1, 11});
`endif

    do_reset();
    chk("reset_busy", scan_busy, 0);
    chk("reset_hit", alarm_hit, 0);
    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0, tbl[i].re, tbl[i].ra);
      chk("tbl_wr_err", bus.wr_err, tbl[i].e_err);
      chk("tbl_rd_valid", bus.rd_valid, tbl[i].e_rvld);
      if (tbl[i].e_rvld != 0) chk("tbl_rd_data", bus.rd_data, tbl[i].e_rdat);
    end

`ifdef SHADOW_COMMIT_EN
    do_reset();
    wr(1, 15);
    chk("sh_min_hidden", curr_min, 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1);
    chk("sh_read_hidden", bus.rd_data, 0);
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0);
    chk("sh_commit_min", curr_min, 15);
    chk("sh_commit_busy", scan_busy, 1);
    idle(5);
`else
    // Single match on slot 2.
    do_reset();
    wr(6, 7); wr(7, 30); wr(10, 4); wr(0, 7);
    clear_log();
    wr(1, 30);
    idle(10);
    chk("one_hit_cnt", hit_cnt, 1);
    chk("one_hit_idx", (hit_ix.size() > 0) ? hit_ix[0] : -1, 2);
    chk("one_busy_cycles", busy_cnt, 4);

    // Two matches, slots 0 and 3, three cycles apart.
    do_reset();
    wr(2, 6); wr(3, 0); wr(8, 6); wr(9, 0); wr(10, 9); wr(1, 5); wr(0, 6);
    clear_log();
    wr(1, 0);
    idle(10);
    chk("two_hit_cnt", hit_cnt, 2);
    chk("two_first_idx", (hit_ix.size() > 0) ? hit_ix[0] : -1, 0);
    chk("two_second_idx", (hit_ix.size() > 1) ? hit_ix[1] : -1, 3);
    chk("two_spacing", (hit_cyc.size() > 1) ? hit_cyc[1] - hit_cyc[0] : -1, 3);

    // Mid-scan rewrite to 06:01: slot 0 hit already compared, no slot 3 hit.
    wr(1, 5);
    idle(6);
    clear_log();
    wr(1, 0);
    wr(1, 1);
    idle(8);
    chk("restart_hit_cnt", hit_cnt, 1);
    chk("restart_hit_idx", (hit_ix.size() > 0) ? hit_ix[0] : -1, 0);

    // Reset in the middle of a scan.
    wr(1, 0);
    idle(1);
    clear_log();
    cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2);
    chk("rst_mid_busy", scan_busy, 0);
    chk("rst_mid_hit", alarm_hit, 0);
    chk("rst_mid_rvld", bus.rd_valid, 0);
    idle(8);
    chk("rst_mid_no_hits", hit_cnt, 0);
`endif

    // Random traffic; small values so matches actually occur.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_we, r_cm, r_re;
      int r_a, r_d, r_ra;
      r_rst = ($urandom % 150) == 0;
      r_we  = $urandom % 2;
      r_a   = $urandom_range(0, 12);
      if (r_a == MASKA) r_d = $urandom % 16;
      else if ($urandom % 8 == 0) r_d = $urandom_range(0, 255);
      else r_d = $urandom_range(0, 2);
      r_cm  = ($urandom % 20) == 0;
      r_re  = $urandom % 2;
      r_ra  = $urandom_range(0, 15);
      cycle(r_rst, r_we, r_a, r_d, r_cm, r_re, r_ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
